bpsk_modulator: RTL
===================

# bpsk_modulator

Byte-stream BPSK mapper that sits directly downstream of `sin_generator` in the transmit chain. It accepts data bytes over a valid/ready handshake and serializes them MSB first, one bit per full carrier period of SAMPLE_NUMBER samples. It drives the generator's `en` and selects the generator's `sin_out` (bit 1) or `neg_sin_out` (bit 0) on each sample. Bit boundaries are aligned to the generator's counter wrap, so phase flips only ever occur at sample index 0.

## Interface
Parameters:
- SAMPLE_NUMBER, 256, samples per carrier period; must match the connected `sin_generator`.
- SAMPLE_WIDTH, 12, sample width; must match the generator.
- DATA_WIDTH, 8, bits per input word.

Ports:
- clk  in  1  single clock for the whole block.
- arstn  in  1  asynchronous, active-low reset.
- s_data  in  DATA_WIDTH  input word; bit DATA_WIDTH-1 is transmitted first.
- s_valid  in  1  `s_data` is valid.
- s_ready  out  1  block can accept a word (combinational).
- gen_en  out  1  registered; drives the generator's `en`.
- sin_in  in  SAMPLE_WIDTH  from the generator's `sin_out`.
- neg_sin_in  in  SAMPLE_WIDTH  from the generator's `neg_sin_out`.
- cnt_in  in  $clog2(SAMPLE_NUMBER)  from the generator's `cnt_out`.
- mod_out  out  SAMPLE_WIDTH  registered modulated sample.
- mod_valid  out  1  registered; `mod_out` carries a live sample.
- busy  out  1  state != IDLE.

## Operation
- Registers:
  - `state` ∈ {IDLE, RUN, FLUSH}
  - `shreg[DATA_WIDTH]`
  - `bits_left` (0..DATA_WIDTH)
  - `cur_bit`
  - `sv_d` (gen_en delayed by 1)
- Handshake:
  - `s_ready` = (bits_left == 0) && (state != FLUSH).
  - A transfer occurs on an edge where `s_valid && s_ready`: `shreg` ← `s_data`, `bits_left` ← DATA_WIDTH.
  - `s_data` may change freely when no transfer occurs.
- IDLE: `gen_en` = 0. A transfer moves the block to RUN.
- RUN: `gen_en` = 1.
  - On an edge with `cnt_in == 0` and `bits_left > 0`:
    - `cur_bit` ← `shreg[MSB]`
    - `shreg` ← `shreg << 1`
    - `bits_left` ← `bits_left - 1`
  - On an edge with `cnt_in == SAMPLE_NUMBER-1`:
    - if `bits_left == 0` and no transfer occurs → FLUSH;
    - otherwise stay in RUN.
  - A word accepted during the last bit period of the previous word continues seamlessly, with no gap in `mod_valid`.
- FLUSH: `gen_en` = 0 for exactly 1 cycle, then IDLE. `cur_bit` is held so that sample N-1 is mapped with the correct sign.
- Output mapping:
  - `sv_d` ← `gen_en`.
  - `mod_out` ← `sv_d ? (cur_bit ? sin_in : neg_sin_in) : 0`.
  - `mod_valid` ← `sv_d`.
- Invariant: the generator is only stopped on a wrap, so `cnt_in == 0` whenever the block enters RUN. The block does not check for a misaligned counter.
- Reset (asynchronous, any time including mid-word):
  - state = IDLE, shreg = 0, bits_left = 0, cur_bit = 0, sv_d = 0;
  - gen_en = 0, mod_out = 0, mod_valid = 0, busy = 0;
  - `s_ready` = 1 immediately after reset.
  - A partial word in flight is discarded. The generator must be reset by the same `arstn` so that its counter is also 0.

## Timing
- Accept edge E0 (IDLE) → RUN in cycle 1 with `gen_en` = 1 and `cnt_in` = 0.
- Edge E1: generator presents ROM[0]; `cur_bit` loads the first bit.
- Edge E2: `mod_out` = ±ROM[0] and `mod_valid` = 1. First output is 2 edges after the accept edge.
- Each bit occupies exactly SAMPLE_NUMBER consecutive `mod_valid` cycles. A burst of K back-to-back words gives exactly K·DATA_WIDTH·SAMPLE_NUMBER contiguous valid cycles.
- Latest transfer that avoids a gap: the edge where `cnt_in == SAMPLE_NUMBER-1` of the last bit.
- After the final sample: `gen_en` falls on the edge that enters FLUSH, and `mod_valid` falls 2 edges later.
- Earliest next accept: the first cycle in IDLE.

## Test plan
- Reset values: assert `arstn` low asynchronously mid-cycle → all outputs 0 with no clock edge required; `s_ready` = 1.
- Single word: SAMPLE_NUMBER=8; send 8'hA5 → `mod_valid` high for exactly 64 cycles. Per 8-sample bit, `mod_out` equals the sin ROM for 1-bits and the neg_sin ROM for 0-bits, in the order 1,0,1,0,0,1,0,1.
- Back-to-back: send 8'hFF then 8'h00, with the second `s_valid` asserted early → the second word is accepted during bit 7 of the first. Expect 128 contiguous valid cycles and a single phase flip, exactly at sample 0 of bit 8.
- Late second word: assert the second `s_valid` 1 cycle after the `cnt_in == 7` edge of the last bit → FLUSH and IDLE occur, `mod_valid` has a gap, and the second word restarts with `cnt_in` = 0.
- Backpressure: hold `s_valid` = 1 with changing `s_data` while `s_ready` = 0 → no word is accepted. The value sampled is the one present on the `s_ready` edge.
- Reset mid-word: drop `arstn` during bit 3 → outputs 0 and state IDLE. A new word after release starts at ROM[0] with a 2-edge latency.

Source files
------------

// File: rtl/bpsk_modulator.sv
// bpsk_modulator: byte-stream BPSK mapper placed after sin_generator.
// Serialises each accepted word MSB first, one bit per full carrier period,
// and selects the generator's sin or neg_sin sample according to the bit.
// Bit boundaries follow the generator's counter wrap, so any phase flip
// lands on sample index 0.
module bpsk_modulator #(
    parameter int SAMPLE_NUMBER = 256,
    parameter int SAMPLE_WIDTH  = 12,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                             clk,
    input  logic                             arstn,
    input  logic [DATA_WIDTH-1:0]            s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    output logic                             gen_en,
    input  logic [SAMPLE_WIDTH-1:0]          sin_in,
    input  logic [SAMPLE_WIDTH-1:0]          neg_sin_in,
    input  logic [$clog2(SAMPLE_NUMBER)-1:0] cnt_in,
    output logic [SAMPLE_WIDTH-1:0]          mod_out,
    output logic                             mod_valid,
    output logic                             busy
);

    localparam int CNT_W = $clog2(SAMPLE_NUMBER);
    localparam int BL_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_NUMBER - 1);
    localparam logic [BL_W-1:0]  BL_FULL  = BL_W'(DATA_WIDTH);
    localparam logic [BL_W-1:0]  BL_ONE   = BL_W'(1);

    logic [1:0]            state_q,     state_d;
    logic [DATA_WIDTH-1:0] shreg_q,     shreg_d;
    logic [BL_W-1:0]       bits_left_q, bits_left_d;
    logic                  cur_bit_q,   cur_bit_d;
    logic                  gen_en_q,    gen_en_d;
    logic                  sv_q;        // gen_en delayed by one cycle
    logic [SAMPLE_WIDTH-1:0] mod_out_q;
    logic                  mod_valid_q;
    logic                  xfer;

    // A new word may be taken once the previous one is fully shifted out,
    // except in the single FLUSH cycle where the generator is stopping.
    assign s_ready   = (bits_left_q == '0) && (state_q != ST_FLUSH);
    assign xfer      = s_valid && s_ready;
    assign busy      = (state_q != ST_IDLE);
    assign gen_en    = gen_en_q;
    assign mod_out   = mod_out_q;
    assign mod_valid = mod_valid_q;

    // Next-state logic: handshake, bit shifting on counter wrap, FSM moves.
    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d     = state_q;
        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;
        cur_bit_d   = cur_bit_q;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d     = ST_RUN;
                    shreg_d     = s_data;
                    bits_left_d = BL_FULL;
                end
            end
            ST_RUN: begin
                // Transfer and shift are exclusive: one needs bits_left == 0,
                // the other bits_left > 0.
                if (xfer) begin
                    shreg_d     = s_data;
                    bits_left_d = BL_FULL;
                end else if (cnt_in == '0 && bits_left_q != '0) begin
                    cur_bit_d   = shreg_q[DATA_WIDTH-1];
                    shreg_d     = shreg_q << 1;
                    bits_left_d = bits_left_q - BL_ONE;
                end
                // Stop only on a wrap so the generator counter rests at 0.
                if (cnt_in == CNT_LAST && bits_left_q == '0 && !xfer) begin
                    state_d = ST_FLUSH;
                end
            end
            // cur_bit is held here so the last sample keeps its sign.
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        gen_en_d = (state_d == ST_RUN);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge arstn) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!arstn) begin
            // NOTE: the shift register is reset too so a discarded partial
            // word can never leak into the next transmission.
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bits_left_q <= '0;
            cur_bit_q   <= 1'b0;
            gen_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bits_left_q <= bits_left_d;
            cur_bit_q   <= cur_bit_d;
            gen_en_q    <= gen_en_d;
        end
    end

    // Output pipeline: the generator's sample lags gen_en by one cycle,
    // so the sign selection is aligned through sv_q.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sv_q        <= 1'b0;
            mod_out_q   <= '0;
            mod_valid_q <= 1'b0;
        end else begin
            sv_q        <= gen_en_q;
            mod_out_q   <= sv_q ? (cur_bit_q ? sin_in : neg_sin_in) : '0;
            mod_valid_q <= sv_q;
        end
    end

endmodule
